// File: rtl/latch_sr_pkg.sv
// Shared definitions for the latch-based shift register array:
// phase FSM states, gap-counter sizing and parameter legality checks.
package latch_sr_pkg;

    // Phase sequencer states: one PH pulse per phase, each followed by dead time
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        GAP1 = 3'd2,
        PH2  = 3'd3,
        GAP2 = 3'd4
    } phase_state_t;

    localparam int MIN_WIDTH = 1;
    localparam int MIN_DEPTH = 1;
    localparam int MIN_GAP   = 1;

    // Width of a counter that walks 0..gap_cycles-1, never narrower than one bit
    function automatic int gap_cnt_width(input int gap_cycles);
        return (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
    endfunction

    // A dead time of at least one cycle is what keeps phi1 and phi2 apart
    function automatic bit params_legal(input int width, input int depth, input int gap_cycles);
        return (width >= MIN_WIDTH) && (depth >= MIN_DEPTH) && (gap_cycles >= MIN_GAP);
    endfunction

endpackage

// File: rtl/latch_sr_stage.sv
// One WIDTH-bit stage of the array: a master latch open on phi1 feeding a
// slave latch open on phi2, both cleared asynchronously by rst.
module latch_sr_stage
    import latch_sr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d,
    input  logic             phi1,
    input  logic             phi2,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] master;

    // Master latch follows the stage input while phi1 is high
    always_latch begin
        if (rst) begin
            master <= '0;
        end else if (phi1) begin
            master <= d;
        end
    end

    // Slave latch follows the master while phi2 is high
    always_latch begin
        if (rst) begin
            q <= '0;
        end else if (phi2) begin
            q <= master;
        end
    end

endmodule

// File: rtl/latch_sr_array.sv
// Multi-lane shift register made of master/slave latch stages, clocked by an
// internal two-phase non-overlapping generator that runs one shift per request.
// Optional tap port enabled by defining LATCH_SR_TAP_EN.
module latch_sr_array
    import latch_sr_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           shift_en,
    input  logic [WIDTH-1:0]               din,
`ifdef LATCH_SR_TAP_EN
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] tap_sel,
    output logic [WIDTH-1:0]               tap_out,
`endif
    output logic [WIDTH-1:0]               dout,
    output logic                           busy,
    output logic                           shift_done,
    output logic [$clog2(DEPTH+1)-1:0]     fill,
    output logic                           valid
);

    localparam int GW = gap_cnt_width(GAP_CYCLES);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    // Refuse to elaborate a configuration that could overlap the phases
    if (!params_legal(WIDTH, DEPTH, GAP_CYCLES)) begin : g_param_check
        $error("latch_sr_array: WIDTH, DEPTH and GAP_CYCLES must all be >= 1");
    end

    phase_state_t     state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             valid_q, valid_d;
    logic             phi1_q, phi1_d;
    logic             phi2_q, phi2_d;
    logic             gap_last;
    logic             accept;

    logic [WIDTH-1:0] stage_out [DEPTH];

    assign gap_last = (gap_q == GAP_LAST);
    assign accept   = shift_en && ((state_q == IDLE) || ((state_q == GAP2) && gap_last));

    // State register, phase outputs and gap counter; rst aborts any shift in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
            phi1_q  <= 1'b0;
            phi2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            phi1_q  <= phi1_d;
            phi2_q  <= phi2_d;
        end
    end

    // Next-state logic: a shift starts from IDLE or chains straight off the last GAP2 cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = PH1;
            PH1:     state_d = GAP1;
            GAP1:    if (gap_last) state_d = PH2;
            PH2:     state_d = GAP2;
            GAP2:    if (gap_last) state_d = accept ? PH1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Dead-time counter runs only inside GAP states and is back at zero on leaving them
    always_comb begin
        gap_d = '0;
        if (((state_q == GAP1) || (state_q == GAP2)) && !gap_last) begin
            gap_d = gap_q + GW'(1);
        end
    end

    // Outputs: phases are decoded from the next state so they leave a flop glitch-free
    always_comb begin
        phi1_d     = (state_d == PH1);
        phi2_d     = (state_d == PH2);
        busy       = (state_q != IDLE);
        shift_done = (state_q == GAP2) && gap_last;
    end

    // Capture the input word only on the edge that launches a shift
    always_comb begin
        cap_d = accept ? din : cap_q;
    end

    // Fill counts completed shifts up to DEPTH; valid tracks the saturated value
    always_comb begin
        fill_d = fill_q;
        if (shift_done && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FW'(1);
        end
        valid_d = (fill_d == FILL_MAX);
    end

    // Data-path registers: capture word, fill counter and valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q   <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cap_q   <= cap_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
        end
    end

    // Latch chain: stage 0 reads the capture register, each later stage the previous slave
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] stage_in;
        if (i == 0) begin : g_head
            assign stage_in = cap_q;
        end else begin : g_link
            assign stage_in = stage_out[i-1];
        end
        latch_sr_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .d    (stage_in),
            .phi1 (phi1_q),
            .phi2 (phi2_q),
            .rst  (rst),
            .q    (stage_out[i])
        );
    end

    assign dout  = stage_out[DEPTH-1];
    assign fill  = fill_q;
    assign valid = valid_q;

`ifdef LATCH_SR_TAP_EN
    // Tap mux: any stage's slave output, zero for a select past the last stage
    always_comb begin
        tap_out = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (int'(tap_sel) == k) begin
                tap_out = stage_out[k];
            end
        end
    end
`endif

endmodule

// File: doc/latch_sr_array.md
Name: latch_sr_array

Overview:
- Parametrised multi-lane shift register built from level-sensitive latch pairs.
- Driven by an internal two-phase, non-overlapping clock generator with a programmable dead time.
- Generalises the single-bit, free-running 1-bit latch chain in three ways: WIDTH lanes, on-demand shifts with a start/done handshake, and a fill counter with a valid flag.
- Instantiated under the top-level tt_um_ wrapper; din and dout map to the dedicated I/O pins.

Parameters:
- WIDTH, 4: lanes (bits per stage); must be ≥ 1.
- DEPTH, 8: number of stages, each a master/slave latch pair; must be ≥ 1.
- GAP_CYCLES, 1: dead clk cycles after each phase pulse; must be ≥ 1, which guarantees non-overlap.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- shift_en  in  1  request one shift.
- din  in  WIDTH  word to shift in.
- dout  out  WIDTH  slave output of stage DEPTH-1.
- busy  out  1  shift sequence in progress.
- shift_done  out  1  one-cycle pulse at the end of each shift.
- fill  out  $clog2(DEPTH+1)  shifts since reset, saturating at DEPTH.
- valid  out  1  high when fill == DEPTH.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values:
  - FSM = IDLE; phi1 = phi2 = 0.
  - All latches, the capture register, dout, fill, valid, busy and shift_done = 0.
- Asserting rst mid-sequence clears everything immediately and aborts the shift. No shift_done is produced for the aborted shift.
- FSM states and sequence: IDLE → PH1 (1 cycle) → GAP1 (GAP_CYCLES) → PH2 (1 cycle) → GAP2 (GAP_CYCLES).
- Shift period is P = 2 + 2*GAP_CYCLES cycles.
- phi1 and phi2:
  - Registered one-hot outputs, driven from the state register, so they are glitch-free.
  - phi1 is high only in PH1; phi2 is high only in PH2. They are never simultaneously high.
- Start condition:
  - shift_en is sampled only when the FSM is in IDLE, or on the last GAP2 cycle.
  - If sampled high, din is captured into the capture register on that edge and the next state is PH1.
  - On the last GAP2 cycle, a high shift_en gives a back-to-back shift with no IDLE cycle; sustained throughput is one shift per P cycles.
- shift_en is ignored in all other cycles. It is not queued.
- busy is high in every non-IDLE state.
- shift_done is high during the final GAP2 cycle. It coincides with the back-to-back sampling point.
- Latch chain:
  - Master latches of every stage are transparent while phi1 is high; slave latches while phi2 is high.
  - Stage 0 master input = capture register. Stage i master input = slave output of stage i-1.
  - Because phases never overlap, each shift moves data exactly one stage.
- Latency: the word captured on shift n is driven on dout from the PH2 of shift n+DEPTH-1 onward. It is stable at the shift_done of that shift.
- fill increments by one at each shift_done, saturating at DEPTH. valid is registered alongside fill.
- DEPTH=1: dout updates in the PH2 of the shift that captured the word.
- There is no flush or clear other than rst.

Optional Feature:
- Macro: LATCH_SR_TAP_EN.
- Defined:
  - Adds input tap_sel [$clog2(DEPTH)-1:0] and output tap_out [WIDTH-1:0].
  - tap_out = slave output of stage tap_sel. It is combinational from tap_sel and the latches.
  - tap_sel ≥ DEPTH returns 0.
- Undefined: both ports and the tap mux are absent.

Decomposition:
- Package latch_sr_pkg holds:
  - the phase FSM state enum (IDLE, PH1, GAP1, PH2, GAP2);
  - a gap-counter width helper;
  - the parameter legality checks, as constants and functions.
- Sub-module latch_sr_stage: WIDTH-bit master/slave latch pair.
  - Ports: d, phi1, phi2, rst, q.
  - Async active-high clear of both latches.
  - Generate-instantiated DEPTH times.
- FSM, gap counter, capture register and fill counter stay in the parent.

Test Plan (WIDTH=4, DEPTH=8, GAP_CYCLES=1, P=4):
- Reset: pulse rst for 2 cycles → dout=0, fill=0, valid=0, busy=0, phi1=phi2=0; a PH1/PH2 overlap assertion never fires across the whole run.
- Single shift: shift_en=1 for one cycle with din=4'hA → busy high for 4 cycles, shift_done on the 4th cycle, fill=1, dout=0.
- Stream: hold shift_en=1 with din=1..8, one word per P cycles → shift_done exactly every 4 cycles with no IDLE gap; valid rises with the 8th shift_done; dout=1 at that point. A 9th shift with din=9 → dout=2, fill stays 8.
- Ignored request: pulse shift_en during PH1 or GAP1 → still exactly one shift_done; the capture register still holds the first din.
- Mid-op reset: assert rst during PH2 of the 5th streamed shift → all outputs are 0 before the next clk edge; after release, one shift with din=4'h3 gives fill=1 and valid=0.
- Tap (LATCH_SR_TAP_EN): after stream words 1..8 → tap_sel=0 gives 8, tap_sel=3 gives 5, tap_sel=7 gives 1, and tap_out equals dout for tap_sel=7.
